// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// register-zero constant and the control-output bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int unsigned REG_ZERO = 0;

    // Output bundle, ordered from the front of the pipe to the back.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic ex_mem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FLOW = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                    id_ex_we: 1'b1, id_ex_flush: 1'b0,
                                    ex_mem_we: 1'b1, ex_mem_flush: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                      id_ex_we: 1'b0, id_ex_flush: 1'b0,
                                      ex_mem_we: 1'b0, ex_mem_flush: 1'b0};
    localparam ctrl_t CTRL_RESET = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                     id_ex_we: 1'b0, id_ex_flush: 1'b1,
                                     ex_mem_we: 1'b0, ex_mem_flush: 1'b1};
    // Front frozen while EX is occupied; EX/MEM receives bubbles.
    localparam ctrl_t CTRL_MUL = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                   id_ex_we: 1'b0, id_ex_flush: 1'b0,
                                   ex_mem_we: 1'b1, ex_mem_flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-sequencer bus: ID/EX/MEM status in, pipeline-register controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  ex_mul_start;
    logic                  mem_busy;
    logic                  pc_we;
    logic                  if_id_we;
    logic                  if_id_flush;
    logic                  id_ex_we;
    logic                  id_ex_flush;
    logic                  ex_mem_we;
    logic                  ex_mem_flush;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, ex_mul_start, mem_busy,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, ex_mul_start, mem_busy,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use_c
);
    logic rs_match;
    logic rt_match;

    assign rs_match   = id_uses_rs && (id_rs == ex_rd);
    assign rt_match   = id_uses_rt && (id_rt == ex_rd);
    // Register zero is hard-wired, so a load targeting it never hazards.
    assign load_use_c = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO)) && (rs_match || rt_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch flushes, multi-cycle multiply occupancy and data-memory wait states.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned MUL_CNT_W = 4;

    state_e                 state_q, state_d;
    state_e                 ret_q, ret_d;
    state_e                 eff_state;
    logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]       stall_q;
    logic                   load_use;
    ctrl_t                  ctrl;
    ctrl_t                  ctrl_out;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .load_use_c  (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // On the cycle mem_busy drops, MEM_WAIT decodes exactly as the state it interrupted.
    always_comb begin
        ctrl      = CTRL_FLOW;
        state_d   = state_q;
        ret_d     = ret_q;
        mul_cnt_d = mul_cnt_q;
        eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (state_q == MEM_WAIT && bus.mem_busy) begin
            ctrl = CTRL_FREEZE;
        end else begin
            state_d = eff_state;
            case (eff_state)
                MUL_BUSY: begin
                    if (bus.mem_busy) begin
                        ctrl    = CTRL_FREEZE;
                        ret_d   = MUL_BUSY;
                        state_d = MEM_WAIT;
                    end else begin
                        ctrl      = CTRL_MUL;
                        mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
                        if (mul_cnt_q <= MUL_CNT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    if (bus.mem_busy) begin
                        ctrl    = CTRL_FREEZE;
                        ret_d   = RUN;
                        state_d = MEM_WAIT;
                    end else if (bus.ex_mul_start) begin
                        ctrl      = CTRL_MUL;
                        mul_cnt_d = MUL_CNT_W'(MUL_LAT - 1);
                        state_d   = MUL_BUSY;
                    end else if (bus.ex_branch_taken) begin
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_we       = 1'b0;
                        ctrl.if_id_we    = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign ctrl_out = rst_n ? ctrl : CTRL_RESET;

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!ctrl_out.pc_we && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.pc_we        = ctrl_out.pc_we;
    assign bus.if_id_we     = ctrl_out.if_id_we;
    assign bus.if_id_flush  = ctrl_out.if_id_flush;
    assign bus.id_ex_we     = ctrl_out.id_ex_we;
    assign bus.id_ex_flush  = ctrl_out.id_ex_flush;
    assign bus.ex_mem_we    = ctrl_out.ex_mem_we;
    assign bus.ex_mem_flush = ctrl_out.ex_mem_flush;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, plus a CNT_W=4 copy for counter saturation.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  sbus ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(4), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Advance to just after the next rising edge, then to the mid-cycle sample point.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
        bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0;
        bus.ex_branch_taken = 1'b0; bus.ex_mul_start = 1'b0; bus.mem_busy = 1'b0;
    endtask

    logic exp_flush [6];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        sbus.id_rs = 5'd0; sbus.id_rt = 5'd0;
        sbus.id_uses_rs = 1'b0; sbus.id_uses_rt = 1'b0;
        sbus.ex_mem_read = 1'b0; sbus.ex_rd = 5'd0;
        sbus.ex_branch_taken = 1'b0; sbus.ex_mul_start = 1'b0; sbus.mem_busy = 1'b0;

        sample();
        check("rst_pc_we", 32'(bus.pc_we), 32'd0);
        check("rst_if_id_flush", 32'(bus.if_id_flush), 32'd1);
        check("rst_ex_mem_flush", 32'(bus.ex_mem_flush), 32'd1);
        check("rst_ex_mem_we", 32'(bus.ex_mem_we), 32'd0);
        check("rst_stall", bus.stall_cycles, 32'd0);

        next_cycle();
        rst_n = 1'b1;
        sample();
        check("idle_pc_we", 32'(bus.pc_we), 32'd1);
        check("idle_id_ex_flush", 32'(bus.id_ex_flush), 32'd0);

        // Load-use on rs: one bubble
        next_cycle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
        sample();
        check("lu_pc_we", 32'(bus.pc_we), 32'd0);
        check("lu_if_id_we", 32'(bus.if_id_we), 32'd0);
        check("lu_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        check("lu_ex_mem_we", 32'(bus.ex_mem_we), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        check("lu_after_pc_we", 32'(bus.pc_we), 32'd1);
        check("lu_after_flush", 32'(bus.id_ex_flush), 32'd0);
        check("lu_stall", bus.stall_cycles, 32'd1);

        // Load to r0 never hazards
        next_cycle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        sample();
        check("r0_pc_we", 32'(bus.pc_we), 32'd1);
        check("r0_id_ex_flush", 32'(bus.id_ex_flush), 32'd0);

        // Load-use on rt also hazards
        next_cycle();
        idle_inputs();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
        sample();
        check("lu_rt_pc_we", 32'(bus.pc_we), 32'd0);

        // Branch beats load-use
        next_cycle();
        bus.ex_branch_taken = 1'b1;
        sample();
        check("br_pc_we", 32'(bus.pc_we), 32'd1);
        check("br_if_id_flush", 32'(bus.if_id_flush), 32'd1);
        check("br_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        check("br_stall", bus.stall_cycles, 32'd2);
        next_cycle();
        idle_inputs();
        sample();
        check("br_stall_after", bus.stall_cycles, 32'd2);

        // Multiply: 4-cycle freeze, branch ignored while busy
        next_cycle();
        bus.ex_mul_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("mul_pc_we_%0d", i), 32'(bus.pc_we), 32'd0);
            check($sformatf("mul_ex_mem_flush_%0d", i), 32'(bus.ex_mem_flush), 32'd1);
            next_cycle();
            bus.ex_mul_start    = 1'b0;
            bus.ex_branch_taken = (i == 1);
        end
        bus.ex_branch_taken = 1'b0;
        sample();
        check("mul_done_pc_we", 32'(bus.pc_we), 32'd1);
        check("mul_done_ex_mem_flush", 32'(bus.ex_mem_flush), 32'd0);
        check("mul_stall", bus.stall_cycles, 32'd6);

        // mem_busy for 3 cycles in RUN
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.mem_busy = 1'b1;
            sample();
            check($sformatf("mw_pc_we_%0d", i), 32'(bus.pc_we), 32'd0);
            check($sformatf("mw_ex_mem_we_%0d", i), 32'(bus.ex_mem_we), 32'd0);
            check($sformatf("mw_if_id_flush_%0d", i), 32'(bus.if_id_flush), 32'd0);
        end
        next_cycle();
        bus.mem_busy = 1'b0;
        sample();
        check("mw_done_pc_we", 32'(bus.pc_we), 32'd1);
        check("mw_done_ex_mem_we", 32'(bus.ex_mem_we), 32'd1);
        check("mw_stall", bus.stall_cycles, 32'd9);

        // Multiply interrupted by mem_busy in its second busy cycle: 6-cycle freeze
        exp_flush = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            bus.ex_mul_start = (i == 0);
            bus.mem_busy     = (i == 2) || (i == 3);
            sample();
            check($sformatf("mulmw_pc_we_%0d", i), 32'(bus.pc_we), 32'd0);
            check($sformatf("mulmw_ex_mem_flush_%0d", i), 32'(bus.ex_mem_flush), 32'(exp_flush[i]));
        end
        next_cycle();
        idle_inputs();
        sample();
        check("mulmw_done_pc_we", 32'(bus.pc_we), 32'd1);
        check("mulmw_stall", bus.stall_cycles, 32'd15);

        // Reset asserted mid-multiply, between edges
        next_cycle();
        bus.ex_mul_start = 1'b1;
        next_cycle();
        bus.ex_mul_start = 1'b0;
        sample();
        check("pre_rst_pc_we", 32'(bus.pc_we), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc_we", 32'(bus.pc_we), 32'd0);
        check("async_rst_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        check("async_rst_ex_mem_we", 32'(bus.ex_mem_we), 32'd0);
        check("async_rst_stall", bus.stall_cycles, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("post_rst_pc_we", 32'(bus.pc_we), 32'd1);
        check("post_rst_id_ex_we", 32'(bus.id_ex_we), 32'd1);
        check("post_rst_ex_mem_flush", 32'(bus.ex_mem_flush), 32'd0);
        check("post_rst_stall", bus.stall_cycles, 32'd0);

        // Saturation on the 4-bit counter copy
        next_cycle();
        sbus.mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) next_cycle();
        sample();
        check("sat_partial", 32'(sbus.stall_cycles), 32'd5);
        for (int i = 0; i < 15; i++) next_cycle();
        sample();
        check("sat_full", 32'(sbus.stall_cycles), 32'd15);
        check("sat_pc_we", 32'(sbus.pc_we), 32'd0);
        sbus.mem_busy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enables and flush controls of the PC, IF_ID_Reg, ID/EX and EX/MEM pipeline registers. Handles four cases: load-use hazards, taken-branch flushes, multi-cycle multiply occupancy of EX, and data-memory wait states. Sits beside the datapath; all outputs are consumed by the pipeline registers at the next posedge clk.

Parameters:
REG_ADDR_W, 5, register-file address width
MUL_LAT, 4, total EX-stage cycles a multiply occupies (legal range 2..15)
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
id_rs  input  REG_ADDR_W  source register rs of the instruction in ID
id_rt  input  REG_ADDR_W  source register rt of the instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_ADDR_W  destination register of the instruction in EX
ex_branch_taken  input  1  branch in EX resolved taken
ex_mul_start  input  1  multiply entered EX this cycle
mem_busy  input  1  data memory not ready; MEM must hold
pc_we  output  1  PC load enable
if_id_we  output  1  IF_ID_Reg load enable
if_id_flush  output  1  IF_ID_Reg loads a NOP
id_ex_we  output  1  ID/EX load enable
id_ex_flush  output  1  ID/EX loads a bubble
ex_mem_we  output  1  EX/MEM load enable
ex_mem_flush  output  1  EX/MEM loads a bubble
stall_cycles  output  CNT_W  count of cycles with pc_we=0

Behaviour:
- State register: RUN, MUL_BUSY, MEM_WAIT. Additional registers: mul_cnt (4 bits) and ret_state.
- Outputs are a combinational decode of the current state and inputs, with the same-cycle effect applied at the next edge.
- Reset (rst_n=0, asynchronous):
  - state=RUN, mul_cnt=0, ret_state=RUN, stall_cycles=0.
  - While reset is asserted: all *_we=0, all *_flush=1.
- Hazard term: load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). ex_rd=0 never hazards.
- RUN decode, first match wins:
  1. mem_busy: all *_we=0, no flushes. ret_state<=RUN; go to MEM_WAIT.
  2. ex_mul_start: pc_we=if_id_we=id_ex_we=0, ex_mem_we=1, ex_mem_flush=1. mul_cnt<=MUL_LAT-1; go to MUL_BUSY.
  3. ex_branch_taken: pc_we=1 (loads target), if_id_flush=1, id_ex_flush=1, all other we=1. Branch beats load_use.
  4. load_use: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1. Exactly one bubble.
  5. Otherwise all *_we=1, no flushes.
- MUL_BUSY:
  - If mem_busy: everything frozen, mul_cnt holds, ret_state<=MUL_BUSY, go to MEM_WAIT.
  - Otherwise front frozen (pc/if_id/id_ex we=0), ex_mem_flush=1, mul_cnt decrements.
  - When mul_cnt==1, next state is RUN.
  - ex_branch_taken and ex_mul_start are ignored in MUL_BUSY.
  - Total front freeze = MUL_LAT cycles, counting the start cycle.
- MEM_WAIT:
  - While mem_busy=1: all *_we=0, no flushes.
  - Cycle mem_busy falls: decode exactly as ret_state would on that cycle, including transitions. No lost or extra cycle.
- stall_cycles: increments each cycle out of reset with pc_we=0; saturates at all-ones.
- Reset asserted mid-MUL_BUSY or mid-MEM_WAIT: immediate return to RUN, counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding constants (RUN=2'd0, MUL_BUSY=2'd1, MEM_WAIT=2'd2)
  - REG_ZERO constant
  - the output-bundle ordering
- One natural sub-module: hazard_detect. Purely combinational; computes load_use from the ID and EX register fields.
- FSM, counters and output decode stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 that cycle only; stall_cycles 0->1. Repeat with ex_rd=0 -> no stall.
- Branch vs. load-use: branch_taken=1 with a load_use match in the same cycle -> pc_we=1, if_id_flush=1, id_ex_flush=1, stall_cycles unchanged.
- Multiply, MUL_LAT=4: pulse ex_mul_start -> pc_we=0 for exactly 4 consecutive cycles, ex_mem_flush=1 for those 4, then RUN; stall_cycles=4.
- mem_busy high for 3 cycles in RUN -> all we=0 for 3 cycles, then all we=1. Repeat with mem_busy high 2 cycles during MUL_BUSY cycle 2 -> total front freeze 6 cycles, mul count preserved.
- Reset: deassert rst_n mid-MUL_BUSY between clock edges -> outputs go immediately to all we=0/flush=1, state RUN. After release the first cycle is all we=1; stall_cycles=0.
- Saturation: force stall_cycles near all-ones (CNT_W=4 build), hold mem_busy -> counter stops at 4'hF.
